// File: rtl/fp_stream_minmax.sv
// fp_stream_minmax: per-frame min/max/count over a stream of IEEE-754 singles.
// NaN/Inf samples are counted separately and never touch min/max. One result
// per frame is offered on a valid/ready port; input stalls while it is pending.
module fp_stream_minmax #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_min,
  output logic [31:0]      out_max,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_inv_count,
  output logic             out_empty
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [31:0]      min_r, max_r;
  logic [CNT_W-1:0] cnt_r, inv_r;
  logic             valid_r, empty_r;

  // Map a float onto an unsigned key whose integer order is the float order.
  // Both zeros share one key so +0 and -0 tie.
  function automatic logic [31:0] ord_key(input logic [31:0] v);
    if (v[30:0] == 31'd0) return 32'h8000_0000;
    else if (v[31])       return ~v;
    else                  return {1'b1, v[30:0]};
  endfunction

  logic        accept, is_inv, lt_min, gt_max, fresh;
  logic [31:0] key_in;

  assign in_ready = (state != DONE);
  assign accept   = in_valid && in_ready;
  assign is_inv   = &in_data[30:23];
  assign key_in   = ord_key(in_data);
  assign lt_min   = key_in < ord_key(min_r);
  assign gt_max   = key_in > ord_key(max_r);
  // First ordinary sample of the frame seeds both extremes.
  assign fresh    = (state == IDLE);

  // Frame FSM plus accumulators; result outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      min_r   <= '0;
      max_r   <= '0;
      cnt_r   <= '0;
      inv_r   <= '0;
      valid_r <= 1'b0;
      empty_r <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (is_inv) begin
              if (inv_r != '1) inv_r <= inv_r + CNT_W'(1);
            end else begin
              if (cnt_r != '1) cnt_r <= cnt_r + CNT_W'(1);
              if (fresh || lt_min) min_r <= in_data;
              if (fresh || gt_max) max_r <= in_data;
            end
            if (in_last) begin
              state   <= DONE;
              valid_r <= 1'b1;
              // Empty only if nothing ordinary was held before nor is now.
              empty_r <= fresh && is_inv;
            end else if (!is_inv) begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state   <= IDLE;
            min_r   <= '0;
            max_r   <= '0;
            cnt_r   <= '0;
            inv_r   <= '0;
            valid_r <= 1'b0;
            empty_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid     = valid_r;
  assign out_empty     = empty_r;
  assign out_min       = min_r;
  assign out_max       = max_r;
  assign out_count     = cnt_r;
  assign out_inv_count = inv_r;

endmodule

// File: tb/tb_fp_stream_minmax.sv
// Bench for fp_stream_minmax: directed frame table, stall/reset/saturation
// sequences, and a randomized run against a behavioural reference.
module tb_fp_stream_minmax;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready, out_valid, out_empty;
  logic [31:0]   out_min, out_max;
  logic [CW-1:0] out_count, out_inv_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_stream_minmax #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max), .out_count(out_count),
    .out_inv_count(out_inv_count), .out_empty(out_empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one sample, hold until accepted. Returns at posedge+1 after transfer.
  task automatic send(input logic [31:0] d, input logic l, input int gap);
    logic r;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int t = 0; ; t++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) break;
      if (t > 60) begin chk("send_timeout", 32'd1, 32'd0); break; end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] mn, input logic [31:0] mx,
                         input int cnt, input int inv, input logic emp);
    chk({tag, "_min"}, out_min, mn);
    chk({tag, "_max"}, out_max, mx);
    chk({tag, "_cnt"}, 32'(out_count), 32'(cnt));
    chk({tag, "_inv"}, 32'(out_inv_count), 32'(inv));
    chk({tag, "_emp"}, 32'(out_empty), 32'(emp));
  endtask

  // Acknowledge the pending result and check the cleared state.
  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ack_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_ack_min"}, out_min, 32'h0);
    chk({tag, "_ack_cnt"}, 32'(out_count), 32'd0);
  endtask

  // Reference ordering written directly from sign/magnitude rules.
  function automatic bit ref_lt(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 0 && b[30:0] == 0) return 1'b0;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  typedef struct {
    int               n;
    logic [3:0][31:0] d;
    logic [31:0]      emin, emax;
    int               ecnt, einv;
    logic             eemp;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{3, {32'h0, 32'h40600000, 32'hC0000000, 32'h3F800000}, 32'hC0000000, 32'h40600000, 3, 0, 1'b0};
    vt[1] = '{2, {32'h0, 32'h0, 32'h00000000, 32'h80000000}, 32'h80000000, 32'h80000000, 2, 0, 1'b0};
    vt[2] = '{3, {32'h0, 32'h7FC00000, 32'h3F000000, 32'h7F800000}, 32'h3F000000, 32'h3F000000, 1, 2, 1'b0};
    vt[3] = '{1, {32'h0, 32'h0, 32'h0, 32'h7F800000}, 32'h0, 32'h0, 0, 1, 1'b1};
    vt[4] = '{1, {32'h0, 32'h0, 32'h0, 32'h3F800000}, 32'h3F800000, 32'h3F800000, 1, 0, 1'b0};
    vt[5] = '{4, {32'hFF800000, 32'hBF000000, 32'hC0400000, 32'hBF800000}, 32'hC0400000, 32'hBF000000, 3, 1, 1'b0};
    vt[6] = '{4, {32'h80000001, 32'h00000000, 32'h00800000, 32'h00000001}, 32'h80000001, 32'h00800000, 4, 0, 1'b0};
    vt[7] = '{2, {32'h0, 32'h0, 32'h80000000, 32'h00000000}, 32'h00000000, 32'h00000000, 2, 0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_min", out_min, 32'h0);
    chk("rst_max", out_max, 32'h0);
    chk("rst_cnt", 32'(out_count), 32'd0);
    chk("rst_inv", 32'(out_inv_count), 32'd0);
    chk("rst_emp", 32'(out_empty), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed frame table
    for (int v = 0; v < 8; v++) begin
      for (int s = 0; s < vt[v].n; s++)
        send(vt[v].d[s], s == vt[v].n - 1, s % 2);
      chk($sformatf("v%0d_lat", v), 32'(out_valid), 32'd1);
      chk_res($sformatf("v%0d", v), vt[v].emin, vt[v].emax, vt[v].ecnt, vt[v].einv, vt[v].eemp);
      ack($sformatf("v%0d", v));
    end

    // Backpressure on the result while upstream keeps offering a sample
    send(32'h3F800000, 1'b0, 0);
    send(32'hC0000000, 1'b1, 0);
    in_valid = 1'b1; in_data = 32'h40000000; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk_res("hold", 32'hC0000000, 32'h3F800000, 2, 0, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_rel_valid", 32'(out_valid), 32'd0);
    chk("hold_rel_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("next_valid", 32'(out_valid), 32'd1);
    chk_res("next", 32'h40000000, 32'h40000000, 1, 0, 1'b0);
    ack("next");

    // Reset mid-frame discards the partial frame
    send(32'hC1000000, 1'b0, 0);
    send(32'h7F800000, 1'b0, 0);
    rst_n = 1'b0;
    #2;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_cnt", 32'(out_count), 32'd0);
    chk("mrst_inv", 32'(out_inv_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ready", 32'(in_ready), 32'd1);
    send(32'h3F800000, 1'b1, 0);
    chk_res("mrst", 32'h3F800000, 32'h3F800000, 1, 0, 1'b0);
    ack("mrst");

    // Counter saturation: 17 increasing ordinary, 16 invalid
    for (int i = 0; i < 17; i++) send({1'b0, 8'(100 + i), 23'd0}, 1'b0, 0);
    for (int i = 0; i < 16; i++) send(32'h7FC00001, i == 15, 0);
    chk_res("sat", {1'b0, 8'd100, 23'd0}, {1'b0, 8'd116, 23'd0}, 15, 15, 1'b0);
    ack("sat");

    // Randomized frames with stalls on both sides
    for (int f = 0; f < 1000; f++) begin
      int n, cnt, inv;
      logic [31:0] mn, mx, d;
      bit have, got;
      n = $urandom_range(1, 5);
      cnt = 0; inv = 0; have = 0; mn = 0; mx = 0;
      for (int s = 0; s < n; s++) begin
        case ($urandom_range(0, 9))
          0:       d = {1'($urandom), 8'hFF, 23'($urandom)};
          1:       d = {1'($urandom), 31'd0};
          default: d = {1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)};
        endcase
        if (&d[30:23]) begin
          if (inv < 15) inv++;
        end else begin
          if (cnt < 15) cnt++;
          if (!have) begin mn = d; mx = d; have = 1; end
          else begin
            if (ref_lt(d, mn)) mn = d;
            if (ref_lt(mx, d)) mx = d;
          end
        end
        send(d, s == n - 1, $urandom_range(0, 2));
      end
      got = 0;
      for (int t = 0; t < 40; t++) begin
        out_ready = 1'($urandom);
        @(negedge clk);
        if (out_valid && out_ready) begin
          chk_res($sformatf("rnd%0d", f), mn, mx, cnt, inv, !have);
          got = 1;
        end
        @(posedge clk); #1;
        if (got) break;
      end
      out_ready = 1'b0;
      if (!got) chk($sformatf("rnd%0d_timeout", f), 32'd0, 32'd1);
      chk($sformatf("rnd%0d_cleared", f), 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
